// File: rtl/mem_access_unit_if.sv
// mem_access_unit_if
// Groups the requester handshake and the byte-wide data-memory bus of
// mem_access_unit. Signal names keep the unit's own i/o suffixes: a *_i
// member is driven into the unit and a *_o member is driven by it.
//   slave  : the unit itself (mem_access_unit)
//   master : the environment, i.e. the requester plus the data memory
// Requester: req_i, we_i, word_i, signed_i, addr_i, wdata_i,
//            busy_o, done_o, err_o, rdata_o
// Memory   : mem_addr_o, mem_wdata_o, mem_we_o, mem_re_o, mem_rdata_i
interface mem_access_unit_if;
  logic        req_i;
  logic        we_i;
  logic        word_i;
  logic        signed_i;
  logic [31:0] addr_i;
  logic [31:0] wdata_i;
  logic        busy_o;
  logic        done_o;
  logic        err_o;
  logic [31:0] rdata_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic        mem_we_o;
  logic        mem_re_o;
  logic [31:0] mem_rdata_i;

  modport slave (
    input  req_i, we_i, word_i, signed_i, addr_i, wdata_i, mem_rdata_i,
    output busy_o, done_o, err_o, rdata_o,
           mem_addr_o, mem_wdata_o, mem_we_o, mem_re_o
  );

  modport master (
    output req_i, we_i, word_i, signed_i, addr_i, wdata_i, mem_rdata_i,
    input  busy_o, done_o, err_o, rdata_o,
           mem_addr_o, mem_wdata_o, mem_we_o, mem_re_o
  );
endinterface

// File: rtl/mem_access_unit.sv
// mem_access_unit
// Turns byte/word load/store requests into a sequence of single-byte
// accesses on a byte-wide data memory. A word takes 4 transfers, a byte 1.
// Ports:
//   clk_i   : clock, all state on the rising edge
//   rst_i   : synchronous active-low reset
//   bus     : mem_access_unit_if.slave (requester handshake + memory bus)
// Parameter:
//   BIG_ENDIAN : 1 -> byte at addr+0 is bits [31:24]; 0 -> bits [7:0]
// Optional feature:
//   MAU_ALIGN_CHECK_EN : when defined, misaligned word requests complete
//                        immediately with err_o and no memory access.
//
// state | meaning
// IDLE  | waiting for req_i; request fields latched on acceptance
// XFER  | one byte moved per cycle, cnt selects the byte
// DONE  | one-cycle done_o pulse, req_i ignored
module mem_access_unit #(
  parameter bit BIG_ENDIAN = 1'b1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  mem_access_unit_if.slave bus
);
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [1:0]  r_cnt;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [31:0] r_rdata;
  logic [31:0] r_buf;
  logic        r_we;
  logic        r_word;
  logic        r_signed;

  logic        w_last;
  logic        w_misalign;
  logic        w_xfer;
  logic [1:0]  w_lane;
  logic [7:0]  w_st_byte;
  logic [7:0]  w_ld_byte;
  logic [31:0] w_buf_nxt;
  logic [31:0] w_ld_result;
  logic        w_unused_rdata_hi;

  assign w_last = r_word ? (r_cnt == 2'd3) : 1'b1;

  // Bit lane (in bytes from bit 0) that byte cnt of the word occupies.
  assign w_lane    = BIG_ENDIAN ? (2'd3 - r_cnt) : r_cnt;
  assign w_st_byte = r_word ? r_wdata[{w_lane, 3'b000} +: 8] : r_wdata[7:0];
  assign w_ld_byte = bus.mem_rdata_i[7:0];
  assign w_unused_rdata_hi = ^bus.mem_rdata_i[31:8];

  // Final load value is formed at the last XFER edge so rdata_o only
  // changes when a load enters DONE.
  always_comb begin
    w_buf_nxt = r_buf;
    w_buf_nxt[{w_lane, 3'b000} +: 8] = w_ld_byte;
  end

  assign w_ld_result = r_word ? w_buf_nxt
                              : {{24{r_signed & w_ld_byte[7]}}, w_ld_byte};

`ifdef MAU_ALIGN_CHECK_EN
  assign w_misalign = bus.word_i & (bus.addr_i[1:0] != 2'b00);
`else
  assign w_misalign = 1'b0;
`endif

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (bus.req_i) w_state_nxt = w_misalign ? DONE : XFER;
      XFER:    if (w_last) w_state_nxt = DONE;
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      r_state  <= IDLE;
      r_cnt    <= 2'd0;
      r_rdata  <= 32'h0;
      r_buf    <= 32'h0;
      r_addr   <= 32'h0;
      r_wdata  <= 32'h0;
      r_we     <= 1'b0;
      r_word   <= 1'b0;
      r_signed <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      case (r_state)
        IDLE: begin
          if (bus.req_i) begin
            r_addr   <= bus.addr_i;
            r_wdata  <= bus.wdata_i;
            r_we     <= bus.we_i;
            r_word   <= bus.word_i;
            r_signed <= bus.signed_i;
            r_cnt    <= 2'd0;
          end
        end
        XFER: begin
          r_cnt <= r_cnt + 2'd1;
          if (!r_we) begin
            r_buf <= w_buf_nxt;
            if (w_last) r_rdata <= w_ld_result;
          end
        end
        default: ;
      endcase
    end
  end

  // Strobes are gated by rst_i so a reset landing mid-transfer stops the
  // write in that very cycle instead of one cycle later.
  assign w_xfer          = (r_state == XFER) & rst_i;
  assign bus.busy_o      = (r_state == XFER) | ((r_state == IDLE) & bus.req_i);
  assign bus.done_o      = (r_state == DONE);
  assign bus.rdata_o     = r_rdata;
  assign bus.mem_addr_o  = r_addr + {30'h0, r_cnt};
  assign bus.mem_we_o    = w_xfer & r_we;
  assign bus.mem_re_o    = w_xfer & ~r_we;
  assign bus.mem_wdata_o = (w_xfer & r_we) ? {24'h0, w_st_byte} : 32'h0;

`ifdef MAU_ALIGN_CHECK_EN
  logic r_err;
  always_ff @(posedge clk_i) begin
    if (!rst_i) r_err <= 1'b0;
    else if ((r_state == IDLE) && bus.req_i) r_err <= w_misalign;
  end
  assign bus.err_o = (r_state == DONE) & r_err;
`else
  assign bus.err_o = 1'b0;
`endif
endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 SHALL have parameter BIG_ENDIAN, default 1, meaning 1 maps word byte 0 (addr+0) to bits [31:24] and 0 maps it to bits [7:0].
REQ-002 SHALL have port clk_i  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst_i  input  1  reset, synchronous, active-low.
REQ-004 SHALL have ports req_i/we_i/word_i  input  1 each  meaning request valid, 1=store 0=load, and 1=word 0=byte.
REQ-005 SHALL have port signed_i  input  1  meaning sign-extend byte loads.
REQ-006 SHALL have ports addr_i/wdata_i  input  32 each  meaning byte address and store data.
REQ-007 SHALL have ports busy_o/done_o/err_o  output  1 each  meaning pipeline stall, one-cycle completion pulse, and misalignment flag.
REQ-008 SHALL have port rdata_o  output  32  meaning load result.
REQ-009 SHALL have ports mem_addr_o (32), mem_wdata_o (32), mem_we_o (1), mem_re_o (1)  output  meaning byte-wide data-memory drive.
REQ-010 SHALL have port mem_rdata_i  input  32  meaning memory read data; only [7:0] used.

Function
REQ-011 SHALL implement states IDLE, XFER, DONE with a 2-bit byte counter cnt.
REQ-012 SHALL, in IDLE with req_i=1, latch addr_i, wdata_i, we_i, word_i, signed_i at the edge, clear cnt, and enter XFER.
REQ-013 SHALL drive busy_o = (state==XFER) | (state==IDLE & req_i), combinationally, so the requester stalls in the request cycle.
REQ-014 SHALL, in XFER, drive mem_addr_o = latched_addr + cnt (32-bit, wrapping modulo 2^32), and mem_re_o = ~we or mem_we_o = we; strobes SHALL be 0 in all other states.
REQ-015 SHALL, for a store in XFER, put the selected byte on mem_wdata_o[7:0] with [31:8]=0; byte store selects wdata[7:0]; word byte k follows BIG_ENDIAN.
REQ-016 SHALL, for a load, capture mem_rdata_i[7:0] into the byte lane for cnt at each XFER edge.
REQ-017 SHALL perform 4 XFER cycles for a word (cnt 0..3) and 1 for a byte; after the last transfer the unit SHALL enter DONE.
REQ-018 SHALL, in DONE, assert done_o=1 and busy_o=0, ignore req_i, and return to IDLE next cycle.
REQ-019 SHALL hold rdata_o stable from DONE until the next load reaches DONE; byte loads zero-extend or sign-extend from bit 7 per signed_i; stores SHALL leave rdata_o unchanged.
REQ-020 SHALL have latency from request to done_o of 5 cycles for word and 2 cycles for byte, counted from the request cycle.

Reset
REQ-021 SHALL, with rst_i=0 at an edge, enter IDLE, set cnt=0 and rdata_o=0, and drive done_o=0 and err_o=0.
REQ-022 SHALL, on reset during XFER, abort the transfer with no further mem_we_o; bytes already written remain in memory.
REQ-023 SHALL drive mem_we_o=0 and mem_re_o=0 in the cycle after reset.

Configuration
REQ-024 SHALL, with MAU_ALIGN_CHECK_EN defined, treat a word request with addr_i[1:0]!=0 as follows: go from IDLE directly to DONE, issue no memory strobes, pulse err_o with done_o, and leave rdata_o unchanged.
REQ-025 SHALL, without MAU_ALIGN_CHECK_EN, tie err_o to 0 and process misaligned word accesses byte-by-byte from addr_i as given.

Verification
REQ-026 SHALL cover: word store 0x11223344 at addr 4, BIG_ENDIAN=1 -> bytes 4..7 = 11,22,33,44; done_o at cycle 5.
REQ-027 SHALL cover: word load from addr 4 after REQ-026 -> rdata_o=0x11223344; busy_o high in cycles 0-4.
REQ-028 SHALL cover: byte 0x80 at addr 9, byte load with signed_i=1 -> 0xFFFFFF80; with signed_i=0 -> 0x00000080; done_o at cycle 2.
REQ-029 SHALL cover: word store at addr 0xFFFFFFFE -> mem_addr_o sequence FFFFFFFE, FFFFFFFF, 00000000, 00000001.
REQ-030 SHALL cover: rst_i=0 asserted in the second XFER cycle of a word store -> only byte 0 written, state IDLE, busy_o=0 with req_i=0.
REQ-031 SHALL cover: with MAU_ALIGN_CHECK_EN, word load at addr 6 -> no mem_re_o, err_o=done_o=1 at cycle 1; without the macro, bytes 6..9 are read.
